// File: rtl/nand_chan_seq.sv
// One-channel NAND pin sequencer: multi-target CE#, programmable WE#/RE# widths,
// hardware repeat count and guarded R/B# wait. Optional busy timeout: NAND_RB_TIMEOUT_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for an instruction; CE# released after one empty cycle
// S_SETUP     | CE#/CLE/ALE settled, check wr FIFO / rd FIFO space
// S_WAIT_DATA | stalled: wr FIFO empty or rd FIFO full
// S_LO        | WE# or RE# low for TWL cycles
// S_HI        | WE# or RE# high for TWH cycles, beat counter steps at the end
// S_RB_GUARD  | fixed 4-cycle tWB cover before looking at R/B#
// S_RB_WAIT   | waiting for synchronised R/B# of the target to go high
// S_DONE      | instr_ack pulse, back to idle
module nand_chan_seq #(
    parameter int              DW       = 8,
    parameter int              NCE      = 2,
    parameter int              CNTW     = 12,
    parameter int              TWL      = 2,
    parameter int              TWH      = 2,
    parameter logic [DW-1:0]   IDLE_PAT = DW'(8'hAA),
    parameter int              TO_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    output logic            instr_ack,
    output logic            instr_err,
    input  logic [DW-1:0]   wr_data,
    input  logic            wr_valid,
    output logic            wr_ready,
    output logic [DW-1:0]   rd_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [NCE-1:0]  ce_n,
    output logic            cle,
    output logic            ale,
    output logic            we_n,
    output logic            re_n,
    output logic            wp_n,
    input  logic [NCE-1:0]  rb_n,
    output logic [DW-1:0]   dq_out,
    input  logic [DW-1:0]   dq_in,
    output logic            dq_oe,
    output logic            busy
);

    localparam int TGTW   = (NCE > 1) ? $clog2(NCE) : 1;
    localparam int PH_MAX = (TWL > TWH) ? TWL : TWH;
    localparam int PHW    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PHW-1:0]  PH_ONE   = PHW'(1);
    localparam logic [CNTW:0]   BEAT_ONE = (CNTW + 1)'(1);

    localparam logic [3:0] M_NOP     = 4'd0;
    localparam logic [3:0] M_CMD     = 4'd1;
    localparam logic [3:0] M_ADDR    = 4'd2;
    localparam logic [3:0] M_DIN     = 4'd3;
    localparam logic [3:0] M_DOUT    = 4'd4;
    localparam logic [3:0] M_WAIT_RB = 4'd5;
    localparam logic [3:0] M_WP_SET  = 4'd6;
    localparam logic [3:0] M_WP_CLR  = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_DATA,
        S_LO,
        S_HI,
        S_RB_GUARD,
        S_RB_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [3:0]       mode_q;
    logic [TGTW-1:0]  tgt_q;
    logic [CNTW:0]    beat_cnt;
    logic [PHW-1:0]   ph_cnt;
    logic [1:0]       guard_cnt;
    logic [NCE-1:0]   rb_meta;
    logic [NCE-1:0]   rb_sync;

`ifdef NAND_RB_TIMEOUT_EN
    logic [TO_W-1:0]  to_cnt;
`else
    localparam int unused_to_w = TO_W;
`endif

    logic [3:0] in_mode;
    logic [3:0] in_tgt;
    logic       in_illegal;
    logic       is_wr;
    logic       unused_instr;

    assign in_mode      = instr[3:0];
    assign in_tgt       = instr[19:16];
    assign in_illegal   = (in_mode > M_WP_CLR) || ({1'b0, in_tgt} >= 5'(NCE));
    assign is_wr        = (mode_q == M_CMD) || (mode_q == M_ADDR) || (mode_q == M_DIN);
    assign unused_instr = ^{instr[31:20], instr[15:4]};

    // R/B# is fully asynchronous to clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rb_meta <= '0;
            rb_sync <= '0;
        end else begin
            rb_meta <= rb_n;
            rb_sync <= rb_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            mode_q    <= M_NOP;
            tgt_q     <= '0;
            beat_cnt  <= '0;
            ph_cnt    <= '0;
            guard_cnt <= '0;
`ifdef NAND_RB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
            ce_n      <= '1;
            cle       <= 1'b0;
            ale       <= 1'b0;
            we_n      <= 1'b1;
            re_n      <= 1'b1;
            wp_n      <= 1'b0;
            dq_out    <= IDLE_PAT;
            dq_oe     <= 1'b0;
            rd_data   <= IDLE_PAT;
            rd_valid  <= 1'b0;
            wr_ready  <= 1'b0;
            instr_ack <= 1'b0;
            instr_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            instr_ack <= 1'b0;
            instr_err <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        mode_q   <= in_mode;
                        tgt_q    <= in_tgt[TGTW-1:0];
                        beat_cnt <= {1'b0, instr[4 +: CNTW]};
                        busy     <= 1'b1;
                        if (in_illegal) begin
                            instr_ack <= 1'b1;
                            instr_err <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            case (in_mode)
                                M_CMD, M_ADDR, M_DIN, M_DOUT: begin
                                    ce_n  <= ~(NCE'(1) << in_tgt[TGTW-1:0]);
                                    cle   <= (in_mode == M_CMD);
                                    ale   <= (in_mode == M_ADDR);
                                    state <= S_SETUP;
                                end
                                M_WAIT_RB: begin
                                    guard_cnt <= 2'd3;
                                    state     <= S_RB_GUARD;
                                end
                                default: begin
                                    if (in_mode == M_WP_SET) begin
                                        wp_n <= 1'b0;
                                    end else if (in_mode == M_WP_CLR) begin
                                        wp_n <= 1'b1;
                                    end
                                    instr_ack <= 1'b1;
                                    state     <= S_DONE;
                                end
                            endcase
                        end
                    end else begin
                        ce_n <= '1;
                    end
                end

                S_SETUP: begin
                    if (is_wr) begin
                        if (!wr_valid) begin
                            state <= S_WAIT_DATA;
                        end else begin
                            we_n     <= 1'b0;
                            dq_oe    <= 1'b1;
                            dq_out   <= wr_data;
                            wr_ready <= 1'b1;
                            ph_cnt   <= PHW'(TWL - 1);
                            state    <= S_LO;
                        end
                    end else begin
                        if (!rd_ready) begin
                            state <= S_WAIT_DATA;
                        end else begin
                            re_n   <= 1'b0;
                            dq_oe  <= 1'b0;
                            ph_cnt <= PHW'(TWL - 1);
                            state  <= S_LO;
                        end
                    end
                end

                // re-enter SETUP so the strobe always gets a full setup cycle
                S_WAIT_DATA: begin
                    if (is_wr ? wr_valid : rd_ready) begin
                        state <= S_SETUP;
                    end
                end

                S_LO: begin
                    if (ph_cnt == '0) begin
                        we_n   <= 1'b1;
                        re_n   <= 1'b1;
                        ph_cnt <= PHW'(TWH - 1);
                        state  <= S_HI;
                        if (mode_q == M_DOUT) begin
                            rd_data  <= dq_in;
                            rd_valid <= 1'b1;
                        end
                    end else begin
                        ph_cnt <= ph_cnt - PH_ONE;
                    end
                end

                S_HI: begin
                    if (ph_cnt == '0) begin
                        if (beat_cnt == '0) begin
                            cle       <= 1'b0;
                            ale       <= 1'b0;
                            dq_oe     <= 1'b0;
                            dq_out    <= IDLE_PAT;
                            rd_data   <= IDLE_PAT;
                            instr_ack <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            beat_cnt <= beat_cnt - BEAT_ONE;
                            state    <= S_SETUP;
                        end
                    end else begin
                        ph_cnt <= ph_cnt - PH_ONE;
                    end
                end

                S_RB_GUARD: begin
                    if (guard_cnt == 2'd0) begin
`ifdef NAND_RB_TIMEOUT_EN
                        to_cnt <= {{(TO_W - 1){1'b1}}, 1'b0};
`endif
                        state <= S_RB_WAIT;
                    end else begin
                        guard_cnt <= guard_cnt - 2'd1;
                    end
                end

                S_RB_WAIT: begin
                    if (rb_sync[tgt_q]) begin
                        instr_ack <= 1'b1;
                        state     <= S_DONE;
                    end
`ifdef NAND_RB_TIMEOUT_EN
                    else if (to_cnt == '0) begin
                        instr_ack <= 1'b1;
                        instr_err <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
`endif
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
